// File: rtl/imem_loader.sv
// Instruction-memory loader: parses framed host byte stream, writes little-endian
// 32-bit words through a single IM write port and gates the CPU until a frame checks.
module imem_loader #(
   parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
   parameter logic [31:0] TEXT_END  = 32'h0000_4ffc,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [1:0]        err_code,
   output logic [31:0]       entry_pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_CNT,
      S_DATA,
      S_CHK,
      S_ERR
   } state_t;

   state_t            state;
   logic [1:0]        byte_pos;
   logic [31:0]       base;
   logic [7:0]        cnt_lo;
   logic [15:0]       words_left;
   logic [23:0]       word_acc;
   logic [7:0]        sum;
   logic [ADDR_W-1:0] idx;

   logic              accept;
   logic [15:0]       n_full;
   logic [33:0]       span_end;
   logic              range_bad;
   logic [ADDR_W-1:0] base_idx;

   assign accept   = rx_valid && rx_ready;
   assign n_full   = {rx_data, cnt_lo};
   // One past the last byte of the frame; 34 bits so no wrap is possible.
   assign span_end = {2'b00, base} + {16'b0, n_full, 2'b00};
   assign base_idx = base[ADDR_W+1:2] - TEXT_BASE[ADDR_W+1:2];

   always_comb begin
      range_bad = 1'b0;
      if (base[1:0] != 2'b00 || base < TEXT_BASE)
         range_bad = 1'b1;
      else if (n_full != 16'd0)
         range_bad = span_end > ({2'b00, TEXT_END} + 34'd4);
      else
         range_bad = base > TEXT_END;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         byte_pos   <= '0;
         base       <= '0;
         cnt_lo     <= '0;
         words_left <= '0;
         word_acc   <= '0;
         sum        <= '0;
         idx        <= '0;
         rx_ready   <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         err_code   <= '0;
         entry_pc   <= TEXT_BASE;
      end else begin
         rx_ready  <= 1'b1;
         im_we     <= 1'b0;
         load_done <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE, S_ERR: begin
                  if (rx_data == 8'hA5) begin
                     state    <= S_ADDR;
                     byte_pos <= '0;
                     sum      <= '0;
                     cpu_hold <= 1'b1;
                     err_code <= '0;
                  end
               end
               S_ADDR: begin
                  // Shift in from the top so the first (LSB) byte ends up in [7:0].
                  base     <= {rx_data, base[31:8]};
                  byte_pos <= byte_pos + 2'd1;
                  if (byte_pos == 2'd3) state <= S_CNT;
               end
               S_CNT: begin
                  if (byte_pos == 2'd0) begin
                     cnt_lo   <= rx_data;
                     byte_pos <= 2'd1;
                  end else begin
                     byte_pos   <= '0;
                     words_left <= n_full;
                     idx        <= base_idx;
                     if (range_bad) begin
                        state    <= S_ERR;
                        err_code <= 2'd1;
                     end else if (n_full == 16'd0) begin
                        state <= S_CHK;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  sum      <= sum + rx_data;
                  byte_pos <= byte_pos + 2'd1;
                  if (byte_pos == 2'd3) begin
                     im_we      <= 1'b1;
                     im_wdata   <= {rx_data, word_acc};
                     im_addr    <= idx;
                     idx        <= idx + 1'b1;
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1) state <= S_CHK;
                  end else begin
                     word_acc <= {rx_data, word_acc[23:8]};
                  end
               end
               S_CHK: begin
                  if (rx_data == sum) begin
                     state     <= S_IDLE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                     entry_pc  <= base;
                  end else begin
                     state    <= S_ERR;
                     err_code <= 2'd2;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames compared against a frame-level
// model of expected IM writes, error code, CPU hold and entry PC.
module tb_imem_loader;

   localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
   localparam logic [31:0] TEXT_END  = 32'h0000_4ffc;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        im_we;
   logic [11:0] im_addr;
   logic [31:0] im_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic [1:0]  err_code;
   logic [31:0] entry_pc;

   always #5 clk = ~clk;

   imem_loader #(
      .TEXT_BASE(TEXT_BASE),
      .TEXT_END (TEXT_END),
      .ADDR_W   (12)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_hold (cpu_hold),
      .load_done(load_done),
      .err_code (err_code),
      .entry_pc (entry_pc)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [43:0] wr_q[$];
   int unsigned done_cnt = 0;
   logic [31:0] m_entry;

   always @(negedge clk) begin
      if (im_we) wr_q.push_back({im_addr, im_wdata});
      if (load_done) done_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      int unsigned tries = 0;
      logic acc;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      acc = rx_ready;
      @(posedge clk);
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = rx_ready;
         @(posedge clk);
         tries++;
      end
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      if (!acc) check("rx_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_frame(input string name, input logic [31:0] base, input logic [15:0] n,
                            input logic [7:0] pay[$], input logic [7:0] chk);
      logic [43:0] exp_q[$];
      logic [7:0]  s = 8'd0;
      logic [63:0] off;
      logic [31:0] w;
      longint      lb, last;
      bit          bad_range;
      int unsigned exp_err;
      lb   = longint'(base);
      last = lb + 4 * longint'(n) - 4;
      bad_range = (base[1:0] != 2'b00) || (lb < longint'(TEXT_BASE)) ||
                  ((n != 0) ? (last > longint'(TEXT_END)) : (lb > longint'(TEXT_END)));
      foreach (pay[i]) s = s + pay[i];
      exp_err = bad_range ? 1 : ((chk != s) ? 2 : 0);
      if (!bad_range)
         for (int i = 0; i < int'(n); i++) begin
            off = 64'((lb - longint'(TEXT_BASE)) / 4 + i);
            w   = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
            exp_q.push_back({off[11:0], w});
         end
      wr_q.delete();
      done_cnt = 0;
      send_byte(8'hA5);
      check({name, "_sync_hold"}, 64'(cpu_hold), 64'd1);
      check({name, "_sync_err"}, 64'(err_code), 64'd0);
      for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      if (!bad_range) begin
         foreach (pay[i]) send_byte(pay[i]);
         send_byte(chk);
      end
      repeat (3) @(negedge clk);
      if (exp_err == 0) m_entry = base;
      check({name, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check({name, "_write"}, 64'(wr_q[i]), 64'(exp_q[i]));
      check({name, "_err"}, 64'(err_code), 64'(exp_err));
      check({name, "_hold"}, 64'(cpu_hold), (exp_err == 0) ? 64'd0 : 64'd1);
      check({name, "_done"}, 64'(done_cnt), (exp_err == 0) ? 64'd1 : 64'd0);
      check({name, "_entry"}, 64'(entry_pc), 64'(m_entry));
      check({name, "_ready"}, 64'(rx_ready), 64'd1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ready"}, 64'(rx_ready), 64'd0);
      check({name, "_we"}, 64'(im_we), 64'd0);
      check({name, "_addr"}, 64'(im_addr), 64'd0);
      check({name, "_wdata"}, 64'(im_wdata), 64'd0);
      check({name, "_hold"}, 64'(cpu_hold), 64'd1);
      check({name, "_done"}, 64'(load_done), 64'd0);
      check({name, "_err"}, 64'(err_code), 64'd0);
      check({name, "_entry"}, 64'(entry_pc), 64'(TEXT_BASE));
   endtask

   initial begin
      logic [7:0]  pay[$];
      logic [7:0]  s;
      logic [31:0] base;
      logic [15:0] n;
      int unsigned mode;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      m_entry  = TEXT_BASE;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready_after", 64'(rx_ready), 64'd1);

      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame("t1", 32'h3000, 16'd2, pay, 8'h64);
      pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_frame("t2", 32'h4180, 16'd1, pay, 8'h38);
      pay = '{};
      run_frame("t3_range", 32'h4FFC, 16'd2, pay, 8'h00);
      pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_frame("t3_edge", 32'h4FF8, 16'd2, pay, 8'h24);
      pay = '{};
      run_frame("t4_misalign", 32'h3002, 16'd1, pay, 8'h00);
      run_frame("t4_below", 32'h2FFC, 16'd1, pay, 8'h00);
      pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_frame("t5_chk", 32'h3000, 16'd2, pay, 8'h65);

      // Reset mid-frame after two payload bytes.
      wr_q.delete();
      done_cnt = 0;
      send_byte(8'hA5);
      send_byte(8'h00); send_byte(8'h30); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("t6_rst");
      @(negedge clk);
      reset   = 1'b0;
      m_entry = TEXT_BASE;
      repeat (3) @(negedge clk);
      check("t6_nowrite", 64'(wr_q.size()), 64'd0);
      send_byte(8'h00);
      send_byte(8'hFF);
      repeat (2) @(negedge clk);
      check("t6_garbage_hold", 64'(cpu_hold), 64'd1);
      check("t6_garbage_done", 64'(done_cnt), 64'd0);
      pay = '{};
      run_frame("t6_n0", 32'h3000, 16'd0, pay, 8'h00);

      for (int f = 0; f < 25; f++) begin
         n    = 16'($urandom_range(0, 4));
         mode = $urandom_range(0, 9);
         pay  = '{};
         s    = 8'd0;
         for (int i = 0; i < 4 * int'(n); i++) begin
            pay.push_back(8'($urandom));
            s = s + pay[i];
         end
         base = TEXT_BASE + 32'(4 * $urandom_range(0, 2048 - ((n == 0) ? 1 : int'(n))));
         if (mode == 0)
            base = base | 32'($urandom_range(1, 3));
         else if (mode == 1)
            base = TEXT_BASE - 32'(4 * $urandom_range(1, 64));
         else if (mode == 2)
            base = TEXT_END + 32'(4 * $urandom_range(1, 8)) - ((n == 0) ? 32'd0 : 32'(4 * (int'(n) - 1)));
         if (mode == 3) s = s ^ 8'($urandom_range(1, 255));
         run_frame("rnd", base, n, pay, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
